ps2_key_ctrl: RTL and testbench
===============================

Name: ps2_key_ctrl

Overview:
Sequencer between the PS/2 byte receiver and its consumers (hex display, future keyboard-driven logic). Accepts one received scan-code byte per strobe and resolves E0/F0 prefix sequences with an FSM. Queues complete key events {ext, brk, code} in a small FIFO with a valid/ready interface. Latches the last make and last break codes for the 7-segment display path.

Parameters:
FIFO_DEPTH, 4, event FIFO entries (power of two, >= 2)
TIMEOUT_CYC, 50000, clk cycles allowed between a prefix byte and its code byte before the sequence is abandoned

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  received byte, valid when rx_valid=1
rx_valid  in  1  one-cycle strobe: new byte from receiver
rx_err  in  1  one-cycle strobe: receiver framing/parity error
evt_valid  out  1  FIFO non-empty
evt_ready  in  1  consumer pops head when evt_valid&evt_ready
evt_ext  out  1  head event: E0-prefixed key
evt_brk  out  1  head event: key release (F0)
evt_code  out  8  head event scan code
fifo_level  out  $clog2(FIFO_DEPTH)+1  current entry count
ovf  out  1  sticky: event dropped because FIFO full
ovf_clr  in  1  clears ovf
proto_err  out  1  one-cycle pulse: protocol error/timeout/rx_err
busy  out  1  FSM not in IDLE (prefix pending)
disp_make  out  8  last make code
disp_brk  out  8  last break code

Behaviour:
- Reset: FSM=IDLE, FIFO empty, evt_valid=0, evt_ext/evt_brk/evt_code=0, fifo_level=0, ovf=0, proto_err=0, busy=0, disp_make=disp_brk=8'h00, timeout counter=0.
- FSM states IDLE, EXT, BRK, EXT_BRK; transitions only on rx_valid, rx_err or timeout:
  - IDLE: E0->EXT; F0->BRK; other->emit {0,0,code}, stay IDLE.
  - EXT: F0->EXT_BRK; E0->stay EXT (repeat tolerated, no error); other->emit {1,0,code}, IDLE.
  - BRK: E0 or F0->proto_err, IDLE, nothing emitted; other->emit {0,1,code}, IDLE.
  - EXT_BRK: E0 or F0->proto_err, IDLE; other->emit {1,1,code}, IDLE.
- rx_err from any state: proto_err pulse next cycle, FSM->IDLE, pending prefix discarded. If rx_err and rx_valid occur together, rx_err wins and the byte is ignored.
- Timeout counter: cleared in IDLE and on every rx_valid; increments each cycle otherwise. At TIMEOUT_CYC-1: FSM->IDLE, proto_err pulse, counter cleared.
- Emit: push to FIFO; registered, so evt_valid rises the cycle after the completing rx_valid (1-cycle latency). Head is first-word fall-through on evt_* outputs. When empty, evt_* outputs hold their last values.
- Display latch, updated in the same cycle as the push, independent of FIFO state: make events load disp_make; break events load disp_brk.
- Pop when evt_valid&evt_ready; evt_ready is ignored when empty.
- Full: a push is accepted only if the FIFO is not full or a pop occurs in the same cycle. Otherwise the event is dropped and ovf is set.
- Push and pop together when not empty: level unchanged. Pointers wrap modulo FIFO_DEPTH.
- ovf_clr clears ovf. A simultaneous overflow takes priority, so ovf stays 1.
- busy = (state != IDLE), registered.
- Reset mid-sequence or mid-FIFO: all state discarded immediately.

Test Plan:
- Bytes 1C, F0 1C, with evt_ready=1 -> events {0,0,1C} then {0,1,1C}; disp_make=1C, disp_brk=1C; each evt_valid rises 1 cycle after its completing strobe.
- Bytes E0 75, E0 F0 75 -> events {1,0,75}, {1,1,75}; busy=1 between E0 and 75; proto_err never pulses.
- Byte F0, then no bytes for TIMEOUT_CYC cycles -> proto_err pulse once, busy=0, no event. A following 1C yields {0,0,1C}, not a break event.
- evt_ready=0, six make codes 01..06 -> fifo_level=4, ovf=1, FIFO holds 01..04. Pop all -> 01,02,03,04 in order. ovf_clr -> ovf=0.
- Full FIFO with evt_ready=1 and a new code in the same cycle -> level stays 4, no ovf, head advances. Separately, F0 followed by rx_err -> proto_err pulse, FSM IDLE, the next 2A emitted as make.
- Assert rst_n=0 while in EXT_BRK with 3 queued events -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code sequencer: resolves E0/F0 prefixes into key events,
// queues them in a FWFT FIFO and latches the last make/break codes.
module ps2_key_ctrl #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  input  logic                          rx_err,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic                          evt_ext,
  output logic                          evt_brk,
  output logic [7:0]                    evt_code,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ovf,
  input  logic                          ovf_clr,
  output logic                          proto_err,
  output logic                          busy,
  output logic [7:0]                    disp_make,
  output logic [7:0]                    disp_brk
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [PW:0]   CNT_ONE = 1;
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TO_ONE  = 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] to_cnt_q;
  logic          emit, emit_ext, emit_brk, err_d;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   cnt_q;
  logic          full, pop, push_ok;
  logic [9:0]    push_data;

  always_comb begin
    state_d  = state_q;
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_brk = 1'b0;
    err_d    = 1'b0;
    if (rx_err) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end else if (rx_valid) begin
      unique case (state_q)
        IDLE: begin
          if (rx_data == 8'hE0)      state_d = EXT;
          else if (rx_data == 8'hF0) state_d = BRK;
          else                       emit = 1'b1;
        end
        EXT: begin
          if (rx_data == 8'hF0)      state_d = EXT_BRK;
          else if (rx_data != 8'hE0) begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            state_d  = IDLE;
          end
        end
        BRK: begin
          state_d = IDLE;
          if (rx_data == 8'hE0 || rx_data == 8'hF0) err_d = 1'b1;
          else begin
            emit     = 1'b1;
            emit_brk = 1'b1;
          end
        end
        EXT_BRK: begin
          state_d = IDLE;
          if (rx_data == 8'hE0 || rx_data == 8'hF0) err_d = 1'b1;
          else begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            emit_brk = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && to_cnt_q == TO_LAST) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      to_cnt_q  <= '0;
      proto_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= (state_d == IDLE || rx_valid) ? '0 : to_cnt_q + TO_ONE;
      proto_err <= err_d;
      busy      <= (state_d != IDLE);
    end
  end

  assign full      = (cnt_q == CNT_FULL);
  assign evt_valid = (cnt_q != '0);
  assign pop       = evt_valid && evt_ready;
  assign push_ok   = emit && (!full || pop);
  assign push_data = {emit_ext, emit_brk, rx_data};
  assign fifo_level = cnt_q;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  // Head is held in its own register so it keeps the last popped event when empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ovf       <= 1'b0;
      evt_ext   <= 1'b0;
      evt_brk   <= 1'b0;
      evt_code  <= '0;
      disp_make <= '0;
      disp_brk  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_ONE;
      unique case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase

      if (pop && cnt_q > CNT_ONE)
        {evt_ext, evt_brk, evt_code} <= mem[rd_ptr_q + PTR_ONE];
      else if (push_ok && (cnt_q == '0 || (cnt_q == CNT_ONE && pop)))
        {evt_ext, evt_brk, evt_code} <= push_data;

      if (emit && !push_ok) ovf <= 1'b1;
      else if (ovf_clr)     ovf <= 1'b0;

      if (emit) begin
        if (emit_brk) disp_brk  <= rx_data;
        else          disp_make <= rx_data;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: vector table plus hand-written corner sequences.
module tb_ps2_key_ctrl;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid, rx_err, evt_ready, ovf_clr;
  logic       evt_valid, evt_ext, evt_brk, ovf, proto_err, busy;
  logic [7:0] evt_code, disp_make, disp_brk;
  logic [2:0] fifo_level;

  int n_chk  = 0;
  int n_pass = 0;

  ps2_key_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_err(rx_err), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_ext(evt_ext), .evt_brk(evt_brk), .evt_code(evt_code),
    .fifo_level(fifo_level), .ovf(ovf), .ovf_clr(ovf_clr),
    .proto_err(proto_err), .busy(busy), .disp_make(disp_make), .disp_brk(disp_brk)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       v;
    logic       rdy;
    logic       ev;
    logic [9:0] head;
    int         lvl;
    logic       bsy;
    logic       perr;
    logic [7:0] dm;
    logic [7:0] db;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic cyc(input logic [7:0] d, input logic v, input logic e,
                     input logic r, input logic c);
    @(negedge clk);
    rx_data = d; rx_valid = v; rx_err = e; evt_ready = r; ovf_clr = c;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] head();
    return {evt_ext, evt_brk, evt_code};
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(evt_valid), 0);
    chk({tag, "_head"},  32'(head()), 0);
    chk({tag, "_level"}, 32'(fifo_level), 0);
    chk({tag, "_ovf"},   32'(ovf), 0);
    chk({tag, "_perr"},  32'(proto_err), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_dmake"}, 32'(disp_make), 0);
    chk({tag, "_dbrk"},  32'(disp_brk), 0);
  endtask

  initial begin
    int n;
    logic seen;
    rst_n = 1'b0; rx_data = '0; rx_valid = 0; rx_err = 0; evt_ready = 0; ovf_clr = 0;

    //          d      v  rdy ev  head    lvl bsy perr dm     db
    tbl.push_back('{8'h1C, 1, 1, 1, 10'h01C, 1, 0, 0, 8'h1C, 8'h00});
    tbl.push_back('{8'hF0, 1, 1, 0, 10'h01C, 0, 1, 0, 8'h1C, 8'h00});
    tbl.push_back('{8'h1C, 1, 1, 1, 10'h11C, 1, 0, 0, 8'h1C, 8'h1C});
    tbl.push_back('{8'h00, 0, 1, 0, 10'h11C, 0, 0, 0, 8'h1C, 8'h1C});
    tbl.push_back('{8'hE0, 1, 1, 0, 10'h11C, 0, 1, 0, 8'h1C, 8'h1C});
    tbl.push_back('{8'h75, 1, 1, 1, 10'h275, 1, 0, 0, 8'h75, 8'h1C});
    tbl.push_back('{8'hE0, 1, 1, 0, 10'h275, 0, 1, 0, 8'h75, 8'h1C});
    tbl.push_back('{8'hF0, 1, 1, 0, 10'h275, 0, 1, 0, 8'h75, 8'h1C});
    tbl.push_back('{8'h75, 1, 1, 1, 10'h375, 1, 0, 0, 8'h75, 8'h75});
    tbl.push_back('{8'h00, 0, 1, 0, 10'h375, 0, 0, 0, 8'h75, 8'h75});
    tbl.push_back('{8'hF0, 1, 1, 0, 10'h375, 0, 1, 0, 8'h75, 8'h75});
    tbl.push_back('{8'hE0, 1, 1, 0, 10'h375, 0, 0, 1, 8'h75, 8'h75});
    tbl.push_back('{8'h00, 0, 1, 0, 10'h375, 0, 0, 0, 8'h75, 8'h75});
    tbl.push_back('{8'hE0, 1, 1, 0, 10'h375, 0, 1, 0, 8'h75, 8'h75});
    tbl.push_back('{8'hE0, 1, 1, 0, 10'h375, 0, 1, 0, 8'h75, 8'h75});
    tbl.push_back('{8'h33, 1, 1, 1, 10'h233, 1, 0, 0, 8'h33, 8'h75});
    tbl.push_back('{8'h00, 0, 1, 0, 10'h233, 0, 0, 0, 8'h33, 8'h75});

    #12;
    chk_reset_vals("rst");
    @(negedge clk) rst_n = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].d, tbl[i].v, 1'b0, tbl[i].rdy, 1'b0);
      chk($sformatf("v%0d_valid", i), 32'(evt_valid), 32'(tbl[i].ev));
      chk($sformatf("v%0d_head", i),  32'(head()),    32'(tbl[i].head));
      chk($sformatf("v%0d_level", i), 32'(fifo_level), 32'(tbl[i].lvl));
      chk($sformatf("v%0d_busy", i),  32'(busy),      32'(tbl[i].bsy));
      chk($sformatf("v%0d_perr", i),  32'(proto_err), 32'(tbl[i].perr));
      chk($sformatf("v%0d_dmake", i), 32'(disp_make), 32'(tbl[i].dm));
      chk($sformatf("v%0d_dbrk", i),  32'(disp_brk),  32'(tbl[i].db));
      chk($sformatf("v%0d_ovf", i),   32'(ovf),       0);
    end

    // Timeout: F0 then silence
    cyc(8'hF0, 1, 0, 1, 0);
    chk("to_busy_start", 32'(busy), 1);
    n = 0; seen = 0;
    for (int i = 0; i < TO + 5; i++) begin
      cyc(8'h00, 0, 0, 1, 0);
      n++;
      if (proto_err) begin seen = 1; break; end
    end
    chk("to_seen", 32'(seen), 1);
    chk("to_cycles", 32'(n), 32'(TO));
    chk("to_busy", 32'(busy), 0);
    chk("to_level", 32'(fifo_level), 0);
    cyc(8'h00, 0, 0, 1, 0);
    chk("to_perr_once", 32'(proto_err), 0);
    cyc(8'h1C, 1, 0, 0, 0);
    chk("to_next_head", 32'(head()), 32'h01C);
    chk("to_next_dbrk", 32'(disp_brk), 32'h75);
    cyc(8'h00, 0, 0, 1, 0);
    chk("to_drained", 32'(fifo_level), 0);

    // Overflow: six makes with consumer stalled
    for (int k = 1; k <= 6; k++) cyc(8'(k), 1, 0, 0, 0);
    chk("ovf_level", 32'(fifo_level), 4);
    chk("ovf_flag", 32'(ovf), 1);
    chk("ovf_dmake", 32'(disp_make), 32'h06);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("ovf_pop%0d", k), 32'(head()), 32'(k));
      cyc(8'h00, 0, 0, 1, 0);
    end
    chk("ovf_empty", 32'(evt_valid), 0);
    chk("ovf_hold_head", 32'(head()), 32'h004);
    cyc(8'h00, 0, 0, 0, 1);
    chk("ovf_clr", 32'(ovf), 0);

    // Full FIFO with simultaneous push and pop
    for (int k = 1; k <= 4; k++) cyc(8'(8'h10 + k), 1, 0, 0, 0);
    chk("full_level", 32'(fifo_level), 4);
    cyc(8'h15, 1, 0, 1, 0);
    chk("pp_level", 32'(fifo_level), 4);
    chk("pp_ovf", 32'(ovf), 0);
    chk("pp_head", 32'(head()), 32'h012);
    cyc(8'h16, 1, 0, 0, 1);
    chk("clr_vs_ovf", 32'(ovf), 1);
    chk("clr_vs_ovf_lvl", 32'(fifo_level), 4);
    cyc(8'h00, 0, 0, 0, 1);
    chk("clr2", 32'(ovf), 0);
    for (int k = 2; k <= 5; k++) begin
      chk($sformatf("pp_pop%0d", k), 32'(head()), 32'(8'h10 + k));
      cyc(8'h00, 0, 0, 1, 0);
    end
    chk("pp_drained", 32'(fifo_level), 0);

    // rx_err discards a pending break prefix and beats a simultaneous byte
    cyc(8'hF0, 1, 0, 1, 0);
    chk("err_busy", 32'(busy), 1);
    cyc(8'h1C, 1, 1, 1, 0);
    chk("err_perr", 32'(proto_err), 1);
    chk("err_busy0", 32'(busy), 0);
    chk("err_level", 32'(fifo_level), 0);
    chk("err_dmake", 32'(disp_make), 32'h16);
    cyc(8'h00, 0, 0, 1, 0);
    chk("err_pulse", 32'(proto_err), 0);
    cyc(8'h2A, 1, 0, 0, 0);
    chk("err_next_head", 32'(head()), 32'h02A);
    chk("err_next_dmake", 32'(disp_make), 32'h2A);
    cyc(8'h00, 0, 0, 1, 0);

    // Asynchronous reset while in EXT_BRK with three queued events
    cyc(8'h41, 1, 0, 0, 0);
    cyc(8'h42, 1, 0, 0, 0);
    cyc(8'h43, 1, 0, 0, 0);
    cyc(8'hE0, 1, 0, 0, 0);
    cyc(8'hF0, 1, 0, 0, 0);
    chk("pre_rst_level", 32'(fifo_level), 3);
    chk("pre_rst_busy", 32'(busy), 1);
    cyc(8'h00, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    @(negedge clk) rst_n = 1'b1;
    cyc(8'h00, 0, 0, 1, 0);
    chk("post_rst_valid", 32'(evt_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
